// File: rtl/motion_pkg.sv
// Shared definitions for the maze-car motion sequencer.
// Holds the command op encodings, the sequencer FSM state type, the
// steps_left width, and the packed command word stored in the queue.
package motion_pkg;

  localparam int STEP_W = 16;

  localparam logic [2:0] OP_STOP   = 3'd0;
  localparam logic [2:0] OP_FWD    = 3'd1;
  localparam logic [2:0] OP_TURN_L = 3'd2;
  localparam logic [2:0] OP_TURN_R = 3'd3;
  localparam logic [2:0] OP_UTURN  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SETTLE
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [STEP_W-1:0] steps;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO for the motion sequencer.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (pointers/count only)
//   i_flush    - empties the queue on the next edge; wins over push/pop
//   i_push     - write i_data (ignored when full)
//   i_data     - command word
//   i_pop      - drop the head entry (ignored when empty)
//   o_data     - head entry (valid when !o_empty)
//   o_full     - DEPTH entries held
//   o_empty    - no entries held
module cmd_fifo
  import motion_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_data  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/motion_sequencer.sv
// Motion sequencer: runs queued wheel commands (forward, pivot turns,
// U-turn, stop) as step pulses plus wheel directions for stepmotor, with a
// slow/fast/slow speed profile and an idle settle gap after each command.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   cmd_valid/ready   - command handshake (ready = queue not full)
//   cmd_op, cmd_steps - command op and FWD step count
//   abort             - flush queue and halt on the next edge
//   step_pulse        - one-clk pulse per motor step
//   dir_left/right    - 1 = that wheel turns forward
//   busy              - executing or queue non-empty
//   cmd_done          - one-clk pulse when a command and its settle finish
//   steps_left        - remaining steps of the current command
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_SLOW     = 20000,
  parameter int DIV_FAST     = 8000,
  parameter int RAMP_STEPS   = 16,
  parameter int TURN90_STEPS = 200,
  parameter int SETTLE_CYC   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              step_pulse,
  output logic              dir_left,
  output logic              dir_right,
  output logic              busy,
  output logic              cmd_done,
  output logic [STEP_W-1:0] steps_left
);

  if (2 * TURN90_STEPS > 65535) begin : g_bad_turn
    $error("motion_sequencer: 2*TURN90_STEPS does not fit steps_left");
  end
  if (DIV_FAST > DIV_SLOW || DIV_FAST < 2) begin : g_bad_div
    $error("motion_sequencer: need 2 <= DIV_FAST <= DIV_SLOW");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("motion_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int DIV_W = $clog2(DIV_SLOW + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  function automatic logic [STEP_W-1:0] target_steps(input cmd_t c);
    case (c.op)
      OP_FWD:               return c.steps;
      OP_TURN_L, OP_TURN_R: return STEP_W'(TURN90_STEPS);
      OP_UTURN:             return STEP_W'(2 * TURN90_STEPS);
      default:              return '0;
    endcase
  endfunction

  // {left, right}; the U-turn pivots clockwise like TURN_R.
  function automatic logic [1:0] op_dirs(input logic [2:0] op);
    case (op)
      OP_FWD:    return 2'b11;
      OP_TURN_L: return 2'b01;
      OP_TURN_R: return 2'b10;
      OP_UTURN:  return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

  state_t            r_state;
  cmd_t              r_cmd;
  logic [STEP_W-1:0] r_steps_left;
  logic [STEP_W-1:0] r_issued;
  logic [DIV_W-1:0]  r_div;
  logic [SET_W-1:0]  r_set;
  logic              r_pulse;
  logic              r_done;
  logic              r_dir_l;
  logic              r_dir_r;

  cmd_t              w_head;
  cmd_t              w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_slow;
  logic              w_div_hit;
  logic              w_set_hit;
  logic [STEP_W-1:0] w_target;
  logic [1:0]        w_dirs;

  assign w_push_data = '{op: cmd_op, steps: cmd_steps};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (abort),
    .i_push  (cmd_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready  = ~w_full;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign step_pulse = r_pulse;
  assign cmd_done   = r_done;
  assign dir_left   = r_dir_l;
  assign dir_right  = r_dir_r;
  assign steps_left = r_steps_left;

  // Slow while ramping up (first RAMP_STEPS) and ramping down (last RAMP_STEPS).
  assign w_slow    = (r_issued < STEP_W'(RAMP_STEPS)) ||
                     (r_steps_left <= STEP_W'(RAMP_STEPS));
  assign w_div_hit = (r_div == (w_slow ? DIV_W'(DIV_SLOW - 1) : DIV_W'(DIV_FAST - 1)));
  assign w_set_hit = (r_set == SET_W'(SETTLE_CYC - 1));
  assign w_target  = target_steps(r_cmd);
  assign w_dirs    = op_dirs(r_cmd.op);

  // Head is taken from IDLE, or straight from the end of SETTLE.
  assign w_pop = ~abort & ~w_empty &
                 ((r_state == S_IDLE) | ((r_state == S_SETTLE) & w_set_hit));

  always_ff @(posedge clk) begin
    if (w_pop) r_cmd <= w_head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_steps_left <= '0;
      r_issued     <= '0;
      r_div        <= '0;
      r_set        <= '0;
      r_pulse      <= 1'b0;
      r_done       <= 1'b0;
      r_dir_l      <= 1'b0;
      r_dir_r      <= 1'b0;
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_steps_left <= '0;
      r_issued     <= '0;
      r_div        <= '0;
      r_set        <= '0;
      r_pulse      <= 1'b0;
      r_done       <= 1'b0;
      r_dir_l      <= 1'b0;
      r_dir_r      <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_steps_left       <= w_target;
          {r_dir_l, r_dir_r} <= w_dirs;
          r_issued           <= '0;
          r_div              <= '0;
          r_set              <= '0;
          r_state            <= (w_target == '0) ? S_SETTLE : S_RUN;
        end
        S_RUN: begin
          if (w_div_hit) begin
            r_pulse      <= 1'b1;
            r_steps_left <= r_steps_left - STEP_W'(1);
            r_issued     <= r_issued + STEP_W'(1);
            r_div        <= '0;
            if (r_steps_left == STEP_W'(1)) begin
              r_state <= S_SETTLE;
              r_set   <= '0;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SETTLE: begin
          if (w_set_hit) begin
            r_done <= 1'b1;
            if (!w_empty) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_dir_l <= 1'b0;
              r_dir_r <= 1'b0;
            end
          end else begin
            r_set <= r_set + SET_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
